rand_num: RTL and testbench
===========================

RAND_NUM -- requirements
Module: rand_num

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-003 The port reset SHALL be an input, 1 bit wide, asynchronous and active-high, and SHALL reseed the generator.
REQ-004 The port rand SHALL be an output, 2 bits wide, and carries the pseudo-random value.
REQ-005 The parameter SEED SHALL default to 16'hACE1 and is the reset value of the LFSR state.
REQ-006 The parameter LFSR_W SHALL default to 16 and is the state width; only the value 16 is supported.

Function
REQ-007 The block SHALL hold a 16-bit Fibonacci LFSR state register s[15:0].
- Polynomial: x^16+x^14+x^13+x^11+1.
REQ-008 Feedback SHALL be fb = s[15]^s[13]^s[12]^s[10].
REQ-009 The next state SHALL be {s[14:0], fb}, with exactly one step per rising clk edge while reset=0.
REQ-010 rand SHALL equal s[1:0], driven directly from the register with no combinational path from any input.
REQ-011 Latency: rand SHALL reflect the new state in the same cycle as the clock edge that updates it; there is no handshake and no enable.
REQ-012 The sequence SHALL be free-running, with period 65535 over non-zero states.
REQ-013 Lock-up guard: if s==16'h0000 is ever observed, the next state SHALL be the effective seed, not zero.
REQ-014 The effective seed SHALL be SEED if SEED!=0, else 16'h0001, resolved at elaboration.
REQ-015 Over a full period, each rand value SHALL occur 16384 times, except 2'b00, which SHALL occur 16383 times.

Reset
REQ-016 Asserting reset SHALL immediately (asynchronously) force s to the effective seed, giving rand=2'b01 for the default seed.
REQ-017 While reset is held, s SHALL hold the seed and SHALL NOT advance on clock edges.
REQ-018 The first advance after release SHALL occur on the first rising edge with reset=0.
REQ-019 Reset asserted mid-sequence SHALL discard the current state, with no partial or glitch update on deassertion.
REQ-020 There SHALL be no power-on dependence beyond reset; the output is undefined before the first reset.

Structure
REQ-021 A shared package SHALL hold:
- the LFSR width constant (16);
- the tap positions (15,13,12,10);
- the default seed 16'hACE1.
REQ-022 One sub-module, lfsr_step, SHALL be a purely combinational next-state function with the lock-up guard.
REQ-023 rand_num SHALL instantiate lfsr_step, own the state register, and select the output bits.

Verification
REQ-024 Reset with the default seed: reset=1 -> s=16'hACE1 and rand=2'b01 without any clock edge.
REQ-025 Release reset and apply 3 clocks -> s=16'h59C3, 16'hB387, 16'h670F and rand=2'b11, 2'b11, 2'b11.
REQ-026 Full period from reset, 65535 clocks -> s returns to 16'hACE1, no earlier repeat occurs, and 16'h0000 never appears.
REQ-027 Histogram of rand over one period -> 00:16383, 01:16384, 10:16384, 11:16384.
REQ-028 Force s=16'h0000 (or SEED=0) and apply 1 clock -> s equals the effective seed (16'h0001 when SEED=0).
REQ-029 Assert reset asynchronously mid-cycle after 100 clocks -> s=16'hACE1 immediately, and the sequence replays identically after release.

Source files
------------

// File: rtl/rand_num_pkg.sv
// Shared constants for the rand_num LFSR: width, feedback taps and default seed.
// Also provides the elaboration-time resolution of the effective seed.
package rand_num_pkg;

    localparam int LFSR_WIDTH = 16;
    localparam int NUM_TAPS   = 4;

    // Polynomial x^16+x^14+x^13+x^11+1 expressed as state bit positions
    localparam int TAP_POS [NUM_TAPS] = '{15, 13, 12, 10};

    localparam logic [LFSR_WIDTH-1:0] DEFAULT_SEED = 16'hACE1;

    // An all-zero seed would lock the LFSR, so it is replaced by 1
    function automatic logic [LFSR_WIDTH-1:0] eff_seed(input logic [LFSR_WIDTH-1:0] seed);
        return (seed != '0) ? seed : LFSR_WIDTH'(1);
    endfunction

endpackage

// File: rtl/rand_num_lfsr_step.sv
// Combinational next-state function of the Fibonacci LFSR.
// An all-zero state is steered back to the effective seed so the generator cannot lock up.
module lfsr_step
    import rand_num_pkg::*;
#(
    parameter int                     LFSR_W = LFSR_WIDTH,
    parameter logic [LFSR_WIDTH-1:0]  SEED   = DEFAULT_SEED
) (
    input  logic [LFSR_W-1:0] state_i,
    output logic [LFSR_W-1:0] next_o
);

    localparam logic [LFSR_W-1:0] EFF_SEED = eff_seed(SEED);

    logic [NUM_TAPS-1:0] tap_bits;
    logic                fb;

    for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
        assign tap_bits[gi] = state_i[TAP_POS[gi]];
    end

    assign fb = ^tap_bits;

    always_comb begin
        next_o = {state_i[LFSR_W-2:0], fb};
        if (state_i == '0) begin
            next_o = EFF_SEED;
        end
    end

endmodule

// File: rtl/rand_num.sv
// Free-running 16-bit LFSR pseudo-random source; rand_o is the two LSBs of the state.
// Only LFSR_W = 16 is supported. 'rand' is a reserved word, hence the rand_o port name.
module rand_num
    import rand_num_pkg::*;
#(
    parameter int                     LFSR_W = LFSR_WIDTH,
    parameter logic [LFSR_WIDTH-1:0]  SEED   = DEFAULT_SEED
) (
    input  logic       clk,
    input  logic       reset,
    output logic [1:0] rand_o
);

    localparam logic [LFSR_W-1:0] EFF_SEED = eff_seed(SEED);

    logic [LFSR_W-1:0] s_q;
    logic [LFSR_W-1:0] s_d;

    lfsr_step #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED)
    ) u_step (
        .state_i (s_q),
        .next_o  (s_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q <= EFF_SEED;
        end else begin
            s_q <= s_d;
        end
    end

    // Output comes straight from the state register: no input-to-output path
    assign rand_o = s_q[1:0];

endmodule

// File: tb/tb_rand_num.sv
// Self-checking bench for rand_num: spec vectors, full-period sweep, lock-up guard,
// asynchronous mid-cycle resets and randomized runs against an arithmetic reference model.
module tb_rand_num;

    logic       clk;
    logic       reset;
    logic [1:0] rand_def;
    logic [1:0] rand_z;
    logic [15:0] step_in;
    logic [15:0] step_out_def;
    logic [15:0] step_out_z;

    int tests;
    int fails;

    rand_num dut (
        .clk    (clk),
        .reset  (reset),
        .rand_o (rand_def)
    );

    rand_num #(.SEED(16'h0000)) dut_z (
        .clk    (clk),
        .reset  (reset),
        .rand_o (rand_z)
    );

    lfsr_step u_step_def (
        .state_i (step_in),
        .next_o  (step_out_def)
    );

    lfsr_step #(.SEED(16'h0000)) u_step_z (
        .state_i (step_in),
        .next_o  (step_out_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: multiply by two modulo 2^16 and append the parity of the tap bits
    function automatic logic [15:0] model_next(input logic [15:0] s, input logic [15:0] eff);
        int taps [4];
        int v;
        int fb;
        taps = '{15, 13, 12, 10};
        if (s == 16'h0000) return eff;
        v  = int'(s);
        fb = 0;
        foreach (taps[k]) fb = fb ^ ((v >> taps[k]) & 1);
        return 16'((v * 2 + fb) % 65536);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] s_def;
        logic [1:0]  r_def;
        logic [15:0] s_z;
        logic [1:0]  r_z;
    } vec_t;

    vec_t vecs [3];
    bit   seen [65536];
    int   hist [4];
    logic [15:0] rec_s [100];
    logic [1:0]  rec_r [100];

    initial begin : main
        logic [15:0] m;
        int mism, zero_seen, early, dly, hold, ncyc;

        vecs[0] = '{16'h59C3, 2'b11, 16'h0002, 2'b10};
        vecs[1] = '{16'hB387, 2'b11, 16'h0004, 2'b00};
        vecs[2] = '{16'h670F, 2'b11, 16'h0008, 2'b00};

        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        step_in = 16'h0000;

        // Asynchronous reset, before any clock edge
        #2;
        check("reset_s_default", dut.s_q, 16'hACE1);
        check("reset_rand_default", 16'(rand_def), 16'h0001);
        check("reset_s_seed0", dut_z.s_q, 16'h0001);

        // Held reset does not advance
        tick();
        tick();
        check("hold_s_default", dut.s_q, 16'hACE1);

        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("step%0d_s", i + 1), dut.s_q, vecs[i].s_def);
            check($sformatf("step%0d_rand", i + 1), 16'(rand_def), 16'(vecs[i].r_def));
            check($sformatf("step%0d_s_seed0", i + 1), dut_z.s_q, vecs[i].s_z);
            check($sformatf("step%0d_rand_seed0", i + 1), 16'(rand_z), 16'(vecs[i].r_z));
        end

        // Lock-up guard and random next-state checks on the combinational step
        step_in = 16'h0000;
        #1;
        check("lockup_default", step_out_def, 16'hACE1);
        check("lockup_seed0", step_out_z, 16'h0001);
        for (int i = 0; i < 4; i++) begin
            step_in = 16'($urandom_range(1, 65535));
            #1;
            check($sformatf("step_rand_%h", step_in), step_out_def, model_next(step_in, 16'hACE1));
        end

        // Full period from reset
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        m = 16'hACE1;
        mism = 0; zero_seen = 0; early = 0;
        for (int i = 0; i < 4; i++) hist[i] = 0;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            m = model_next(m, 16'hACE1);
            if (dut.s_q !== m || rand_def !== m[1:0]) mism++;
            if (dut.s_q == 16'h0000) zero_seen++;
            if (i < 65535 && (seen[dut.s_q] || dut.s_q == 16'hACE1)) early++;
            seen[dut.s_q] = 1'b1;
            hist[rand_def]++;
        end
        check("period_model_mismatches", 16'(mism), 16'd0);
        check("period_zero_seen", 16'(zero_seen), 16'd0);
        check("period_early_repeat", 16'(early), 16'd0);
        check("period_returns_seed", dut.s_q, 16'hACE1);
        check("hist_00", 16'(hist[0]), 16'd16383);
        check("hist_01", 16'(hist[1]), 16'd16384);
        check("hist_10", 16'(hist[2]), 16'd16384);
        check("hist_11", 16'(hist[3]), 16'd16384);

        // Mid-cycle reset after 100 clocks, then replay
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            rec_s[i] = dut.s_q;
            rec_r[i] = rand_def;
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midcycle_reset_s", dut.s_q, 16'hACE1);
        check("midcycle_reset_rand", 16'(rand_def), 16'h0001);
        tick();
        check("midcycle_hold_s", dut.s_q, 16'hACE1);
        @(negedge clk);
        reset = 1'b0;
        mism = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (dut.s_q !== rec_s[i] || rand_def !== rec_r[i]) mism++;
        end
        check("replay_mismatches", 16'(mism), 16'd0);

        // Randomized runs with asynchronous resets at random points in the cycle
        m = dut.s_q;
        for (int it = 0; it < 20; it++) begin
            ncyc = $urandom_range(1, 150);
            mism = 0;
            for (int c = 0; c < ncyc; c++) begin
                tick();
                m = model_next(m, 16'hACE1);
                if (dut.s_q !== m || rand_def !== m[1:0]) mism++;
            end
            check($sformatf("rand_run%0d_%0dcyc", it, ncyc), 16'(mism), 16'd0);
            @(posedge clk);
            dly = $urandom_range(1, 8);
            #(dly);
            reset = 1'b1;
            #1;
            check($sformatf("rand_reset%0d_at+%0d", it, dly), dut.s_q, 16'hACE1);
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) tick();
            @(negedge clk);
            reset = 1'b0;
            m = 16'hACE1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
